// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port, single-write-port CPU register file.
// Entry 0 is hardwired to zero and has no storage. After reset, an FSM clears
// entries 1..NumEntries-1 before normal operation. Reads are registered with
// one cycle of latency.
// Optional feature macro: REGFILE_WR_BYPASS_EN. When it is defined, a read
// that hits the address being written in the same cycle returns the new data
// (write-first). When it is not defined, such a read returns the old contents
// (read-before-write).
module regfile_mp #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumEntries   = 32,
  parameter int unsigned NumReadPorts = 2,
  localparam int unsigned AddrWidth   = $clog2(NumEntries)
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  output logic                              init_done_o,
  input  logic                              wr_valid_i,
  input  logic [AddrWidth-1:0]              wr_addr_i,
  input  logic [DataWidth-1:0]              wr_data_i,
  input  logic [NumReadPorts-1:0]           rd_valid_i,
  input  logic [NumReadPorts*AddrWidth-1:0] rd_addr_i,
  output logic [NumReadPorts*DataWidth-1:0] rd_data_o
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                            state_q, state_d;
  logic [AddrWidth-1:0]              cnt_q, cnt_d;
  logic                              init_done_d;

  logic                              wr_hit_c;
  logic                              mem_we_c;
  logic [AddrWidth-1:0]              mem_waddr_c;
  logic [DataWidth-1:0]              mem_wdata_c;
  logic [NumReadPorts*DataWidth-1:0] rd_data_d;

  // Storage for entries 1..NumEntries-1. Entry 0 always reads as zero.
  logic [DataWidth-1:0] mem [1:NumEntries-1];

  // Returns true for an address that maps to a real, writable entry.
  function automatic logic addr_ok(input logic [AddrWidth-1:0] a);
    return (a != '0) && (32'(a) < NumEntries);
  endfunction

  assign wr_hit_c = wr_valid_i && addr_ok(wr_addr_i);

  // State, clear counter and init flag registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= AddrWidth'(1);
      init_done_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_o <= init_done_d;
    end
  end

  // Next-state and write-port steering. CLEAR owns the write port, so writes
  // from writeback are dropped while it runs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_o;
    mem_we_c    = 1'b0;
    mem_waddr_c = wr_addr_i;
    mem_wdata_c = wr_data_i;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q;
        mem_wdata_c = '0;
        cnt_d       = cnt_q + AddrWidth'(1);
        if (cnt_q == AddrWidth'(NumEntries - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          cnt_d       = cnt_q;
        end
      end
      ST_RUN: begin
        mem_we_c = wr_hit_c;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Array write. The contents are never reset; the CLEAR pass zeroes them.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Per-port read selection. Ports are forced to zero during CLEAR and hold
  // their value when they are not enabled.
  always_comb begin : read_sel
    logic [AddrWidth-1:0] ra;
    logic [DataWidth-1:0] val;
    rd_data_d = rd_data_o;
    ra        = '0;
    val       = '0;
    for (int unsigned p = 0; p < NumReadPorts; p++) begin
      ra  = rd_addr_i[p*AddrWidth +: AddrWidth];
      val = '0;
      if (addr_ok(ra)) begin
        val = mem[ra];
      end
`ifdef REGFILE_WR_BYPASS_EN
      if (wr_hit_c && (ra == wr_addr_i)) begin
        val = wr_data_i;
      end
`endif
      if (state_q != ST_RUN) begin
        rd_data_d[p*DataWidth +: DataWidth] = '0;
      end else if (rd_valid_i[p]) begin
        rd_data_d[p*DataWidth +: DataWidth] = val;
      end
    end
  end

  // Registered read data.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp.
// Random and directed stimulus is checked against an array-based reference
// model of the register file.
module tb_regfile_mp;
  localparam int unsigned DW  = 32;
  localparam int unsigned NE  = 32;
  localparam int unsigned NRP = 2;
  localparam int unsigned AW  = 5;

  logic                clk_i = 1'b0;
  logic                reset_ni;
  logic                init_done_o;
  logic                wr_valid_i;
  logic [AW-1:0]       wr_addr_i;
  logic [DW-1:0]       wr_data_i;
  logic [NRP-1:0]      rd_valid_i;
  logic [NRP*AW-1:0]   rd_addr_i;
  logic [NRP*DW-1:0]   rd_data_o;

  int vectors = 0;
  int errors  = 0;

  // Reference model state.
  logic [DW-1:0] model  [NE];
  logic [DW-1:0] exp_rd [NRP];
  logic          exp_done;
  int            clear_left;

  regfile_mp #(.DataWidth(DW), .NumEntries(NE), .NumReadPorts(NRP)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .init_done_o (init_done_o),
    .wr_valid_i  (wr_valid_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .rd_valid_i  (rd_valid_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Architectural value a read of address a would return this cycle.
  function automatic logic [DW-1:0] ref_read(input int a);
    if (a == 0 || a >= int'(NE)) return '0;
`ifdef REGFILE_WR_BYPASS_EN
    if (wr_valid_i && int'(wr_addr_i) == a) return wr_data_i;
`endif
    return model[a];
  endfunction

  // Advance one clock edge, updating the model from the current inputs first.
  task automatic tick();
    if (!reset_ni) begin
      foreach (exp_rd[p]) exp_rd[p] = '0;
      foreach (model[i]) model[i] = '0;
      exp_done   = 1'b0;
      clear_left = NE - 1;
    end else if (clear_left > 0) begin
      foreach (exp_rd[p]) exp_rd[p] = '0;
      clear_left--;
      if (clear_left == 0) exp_done = 1'b1;
    end else begin
      for (int p = 0; p < int'(NRP); p++)
        if (rd_valid_i[p]) exp_rd[p] = ref_read(int'(rd_addr_i[p*AW +: AW]));
      if (wr_valid_i && wr_addr_i != '0) model[wr_addr_i] = wr_data_i;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_valid_i = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    rd_valid_i = '0;
    rd_addr_i  = '0;
  endtask

  task automatic set_rd(input int p, input logic v, input int a);
    rd_valid_i[p]         = v;
    rd_addr_i[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input logic v, input int a, input logic [DW-1:0] d);
    wr_valid_i = v;
    wr_addr_i  = AW'(a);
    wr_data_i  = d;
  endtask

  task automatic test_reset();
    int cycles;
    reset_ni = 1'b0;
    idle();
    #1;
    vectors++;
    if (rd_data_o !== '0) begin
      errors++;
      $display("FAIL reset_rd: got %h want 0", rd_data_o);
    end
    vectors++;
    if (init_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b want 0", init_done_o);
    end
    tick();
    tick();
    reset_ni = 1'b1;
    cycles   = 0;
    while (init_done_o !== 1'b1 && cycles < 100) begin
      set_wr(1'b1, int'($urandom_range(1, NE - 1)), $urandom);
      rd_valid_i = NRP'($urandom);
      rd_addr_i  = (NRP*AW)'($urandom);
      tick();
      cycles++;
      vectors++;
      if (init_done_o !== exp_done) begin
        errors++;
        $display("FAIL clear_done cyc%0d: got %b want %b", cycles, init_done_o, exp_done);
      end
      vectors++;
      if (rd_data_o !== '0) begin
        errors++;
        $display("FAIL clear_rd cyc%0d: got %h want 0", cycles, rd_data_o);
      end
    end
    vectors++;
    if (cycles != int'(NE) - 1) begin
      errors++;
      $display("FAIL clear_len: got %0d want %0d", cycles, NE - 1);
    end
    idle();
  endtask

  task automatic test_clear_reads();
    for (int a = 1; a < int'(NE); a++) begin
      idle();
      for (int p = 0; p < int'(NRP); p++) set_rd(p, 1'b1, ((a + p * 7 - 1) % (NE - 1)) + 1);
      tick();
      for (int p = 0; p < int'(NRP); p++) begin
        vectors++;
        if (rd_data_o[p*DW +: DW] !== 32'h0) begin
          errors++;
          $display("FAIL clear_read a%0d p%0d: got %h want 0", a, p, rd_data_o[p*DW +: DW]);
        end
      end
    end
    idle();
  endtask

  task automatic test_x0();
    idle();
    set_wr(1'b1, 0, 32'hDEADBEEF);
    tick();
    idle();
    for (int p = 0; p < int'(NRP); p++) set_rd(p, 1'b1, 0);
    tick();
    for (int p = 0; p < int'(NRP); p++) begin
      vectors++;
      if (rd_data_o[p*DW +: DW] !== 32'h0) begin
        errors++;
        $display("FAIL x0 p%0d: got %h want 0", p, rd_data_o[p*DW +: DW]);
      end
    end
    idle();
  endtask

  task automatic test_basic();
    idle();
    set_wr(1'b1, 5, 32'h12345678);
    tick();
    set_wr(1'b1, 31, 32'hFFFFFFFF);
    tick();
    idle();
    set_rd(0, 1'b1, 5);
    set_rd(1, 1'b1, 31);
    tick();
    vectors++;
    if (rd_data_o[0 +: DW] !== 32'h12345678) begin
      errors++;
      $display("FAIL basic_p0: got %h want 12345678", rd_data_o[0 +: DW]);
    end
    vectors++;
    if (rd_data_o[DW +: DW] !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL basic_p1: got %h want ffffffff", rd_data_o[DW +: DW]);
    end
    idle();
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] want;
`ifdef REGFILE_WR_BYPASS_EN
    want = 32'h2;
`else
    want = 32'h1;
`endif
    idle();
    set_wr(1'b1, 7, 32'h1);
    tick();
    set_wr(1'b1, 7, 32'h2);
    set_rd(0, 1'b1, 7);
    set_rd(1, 1'b1, 7);
    tick();
    for (int p = 0; p < int'(NRP); p++) begin
      vectors++;
      if (rd_data_o[p*DW +: DW] !== want) begin
        errors++;
        $display("FAIL same_cycle p%0d: got %h want %h", p, rd_data_o[p*DW +: DW], want);
      end
    end
    set_wr(1'b0, 0, '0);
    tick();
    for (int p = 0; p < int'(NRP); p++) begin
      vectors++;
      if (rd_data_o[p*DW +: DW] !== 32'h2) begin
        errors++;
        $display("FAIL same_cycle_after p%0d: got %h want 2", p, rd_data_o[p*DW +: DW]);
      end
    end
    idle();
  endtask

  task automatic test_hold();
    idle();
    set_rd(0, 1'b1, 5);
    set_rd(1, 1'b1, 31);
    tick();
    for (int c = 0; c < 3; c++) begin
      rd_valid_i = '0;
      rd_addr_i  = (NRP*AW)'($urandom);
      set_wr(1'b1, (c == 0) ? 5 : 31, $urandom);
      tick();
      vectors++;
      if (rd_data_o[0 +: DW] !== 32'h12345678) begin
        errors++;
        $display("FAIL hold_p0 c%0d: got %h want 12345678", c, rd_data_o[0 +: DW]);
      end
      vectors++;
      if (rd_data_o[DW +: DW] !== 32'hFFFFFFFF) begin
        errors++;
        $display("FAIL hold_p1 c%0d: got %h want ffffffff", c, rd_data_o[DW +: DW]);
      end
    end
    idle();
  endtask

  task automatic test_random();
    int wa;
    for (int c = 0; c < 400; c++) begin
      wa = int'($urandom_range(0, NE - 1));
      set_wr(($urandom_range(0, 3) != 0), wa, $urandom);
      for (int p = 0; p < int'(NRP); p++)
        set_rd(p, ($urandom_range(0, 4) != 0),
               ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NE - 1)));
      tick();
      for (int p = 0; p < int'(NRP); p++) begin
        vectors++;
        if (rd_data_o[p*DW +: DW] !== exp_rd[p]) begin
          errors++;
          $display("FAIL random c%0d p%0d: got %h want %h", c, p, rd_data_o[p*DW +: DW], exp_rd[p]);
        end
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    int cycles;
    idle();
    set_wr(1'b1, 3, 32'hA5A5A5A5);
    tick();
    idle();
    set_rd(0, 1'b1, 3);
    set_rd(1, 1'b1, 3);
    tick();
    vectors++;
    if (rd_data_o[0 +: DW] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL pre_reset: got %h want a5a5a5a5", rd_data_o[0 +: DW]);
    end
    #2;
    reset_ni = 1'b0;
    #1;
    vectors++;
    if (rd_data_o !== '0 || init_done_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rd=%h done=%b want 0/0", rd_data_o, init_done_o);
    end
    tick();
    reset_ni = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_wr(1'b1, 9, 32'h5555AAAA);
      tick();
    end
    reset_ni = 1'b0;
    #1;
    vectors++;
    if (rd_data_o !== '0 || init_done_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_reset: got rd=%h done=%b want 0/0", rd_data_o, init_done_o);
    end
    tick();
    reset_ni = 1'b1;
    cycles   = 0;
    while (init_done_o !== 1'b1 && cycles < 100) begin
      set_wr(1'b1, 9, 32'h5555AAAA);
      tick();
      cycles++;
    end
    vectors++;
    if (cycles != int'(NE) - 1) begin
      errors++;
      $display("FAIL restart_len: got %0d want %0d", cycles, NE - 1);
    end
    idle();
    set_rd(0, 1'b1, 9);
    set_rd(1, 1'b1, 3);
    tick();
    for (int p = 0; p < int'(NRP); p++) begin
      vectors++;
      if (rd_data_o[p*DW +: DW] !== 32'h0) begin
        errors++;
        $display("FAIL clear_drop p%0d: got %h want 0", p, rd_data_o[p*DW +: DW]);
      end
    end
    idle();
  endtask

  initial begin
    reset_ni   = 1'b0;
    clear_left = NE - 1;
    exp_done   = 1'b0;
    foreach (exp_rd[p]) exp_rd[p] = '0;
    foreach (model[i]) model[i] = '0;
    idle();
    test_reset();
    test_clear_reads();
    test_x0();
    test_basic();
    test_same_cycle();
    test_hold();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Multi-read-port, single-write-port CPU register file. Successor to the 2-read/1-write pipeline register file.
- Sits between decode (read ports) and writeback (write port).
- Adds the following over the previous generation: parametrised read-port count, hardwired-zero entry 0, an FSM that clears every entry after reset, and an optional write-to-read bypass.
- Reads are registered, with 1-cycle latency.

Parameters:
- DataWidth, 32, width of each entry in bits.
- NumEntries, 32, number of architectural registers. Must be ≥ 2. Entry 0 reads as zero.
- NumReadPorts, 2, number of independent read ports, range 1..4.
- AddrWidth (localparam), $clog2(NumEntries), address width for all ports.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_ni  input  1  asynchronous, active-low reset.
- init_done_o  output  1  high once the post-reset clear has completed.
- wr_valid_i  input  1  write enable from writeback.
- wr_addr_i  input  AddrWidth  write address.
- wr_data_i  input  DataWidth  write data.
- rd_valid_i  input  NumReadPorts  per-port read enable.
- rd_addr_i  input  NumReadPorts*AddrWidth  packed read addresses; port p occupies bits [p*AddrWidth +: AddrWidth].
- rd_data_o  output  NumReadPorts*DataWidth  packed registered read data; port p occupies bits [p*DataWidth +: DataWidth].

Behaviour:
- Reset (reset_ni low, asynchronous):
  - rd_data_o = 0, init_done_o = 0.
  - FSM = CLEAR, clear counter = 1.
  - Array contents are not reset directly.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle, writes 0 to entry[counter] and increments the counter.
  - When counter = NumEntries-1 is written, the next state is RUN and init_done_o rises on that same edge.
  - CLEAR takes exactly NumEntries-1 cycles after reset deassertion.
  - RUN: normal operation. The FSM stays in RUN until the next reset.
- During CLEAR:
  - wr_valid_i is ignored; the write is dropped.
  - Every rd_data_o port is forced to 0 on each edge, regardless of rd_valid_i.
- Write (RUN only): on posedge with wr_valid_i=1, wr_addr_i≠0 and wr_addr_i<NumEntries, entry[wr_addr_i] ← wr_data_i. All other writes are discarded.
- Read (RUN only), per port p independently:
  - If rd_valid_i[p]=1: rd_data_o[p] ← (addr=0 or addr≥NumEntries) ? 0 : entry[addr], using array contents from before this edge's write (read-before-write) unless bypass is enabled.
  - If rd_valid_i[p]=0: rd_data_o[p] holds its previous value.
- Latency: rd_data_o is valid 1 cycle after rd_valid_i/rd_addr_i are sampled.
- Multiple ports may read the same address in the same cycle; all receive identical data.
- Reset asserted mid-CLEAR or mid-RUN: outputs clear immediately and CLEAR restarts from entry 1 when reset_ni rises.
- Entry 0 is never written; no storage is required for it.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: in RUN, if wr_valid_i=1, wr_addr_i≠0, wr_addr_i<NumEntries and rd_addr_i[p]=wr_addr_i with rd_valid_i[p]=1, then rd_data_o[p] ← wr_data_i (write-first). This removes the writeback-to-decode hazard.
- Undefined: read-before-write; the same case returns the old entry value.
- Bypass never applies during CLEAR or to address 0.

Test Plan:
- Clear sequence: release reset_ni, count cycles.
  - init_done_o rises after exactly 31 cycles (NumEntries=32).
  - Reads of x1..x31 afterwards return 0x00000000.
- x0 hardwire: write 0xDEADBEEF to addr 0, then read addr 0 on both ports → 0x00000000 one cycle later.
- Write/read basic:
  - Write x5=0x12345678 and x31=0xFFFFFFFF.
  - Next cycle, port0 reads 5 and port1 reads 31 → 0x12345678 and 0xFFFFFFFF; other ports unaffected.
- Same-cycle write+read of x7 (old 0x1, new 0x2):
  - Macro undefined → 0x1.
  - Macro defined → 0x2.
  - Following read → 0x2 in both builds.
- Hold and CLEAR masking:
  - rd_valid_i=0 for 3 cycles → rd_data_o holds its last value.
  - Assert reset_ni=0 mid-run → rd_data_o=0 immediately.
  - Writes issued during CLEAR are dropped (entry reads 0 after init_done_o).
- Mid-CLEAR reset: pulse reset_ni at cycle 10 of CLEAR → init_done_o rises 31 cycles after the second release.
